// File: rtl/mssd_frame_serializer.sv
// Transmit framer: turns a (port, len) descriptor plus a byte stream into
// start bit, 8-bit header, 8*len payload bits and stop bit, one bit per clock.
module mssd_frame_serializer #(
    parameter int unsigned MIN_GAP = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_port,
    input  logic [5:0] req_len,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    output logic       ser_out,
    output logic       busy,
    output logic       frame_done,
    output logic       underrun,
    output logic       len_err
);

    localparam int unsigned PORT_W = 2;
    localparam int unsigned LEN_W  = 6;
    localparam int unsigned BIT_W  = 3;
    localparam int unsigned GAP_W  = 4;
    localparam int unsigned BYTE_W = 8;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((MIN_GAP == 0) ? 0 : MIN_GAP - 1);

    typedef enum logic [2:0] {IDLE, START, HDR, DATA, STOP, GAP} state_t;

    state_t state;
    state_t state_n;

    logic [PORT_W-1:0] port_q, port_n;
    logic [LEN_W-1:0]  len_q, len_n;
    logic [BIT_W-1:0]  bit_cnt, bit_cnt_n;
    logic [LEN_W-1:0]  byte_cnt, byte_cnt_n;
    logic [LEN_W-1:0]  fetched, fetched_n;
    logic [GAP_W-1:0]  gap_cnt, gap_cnt_n;
    logic [BYTE_W-1:0] shreg, shreg_n;
    logic [BYTE_W-1:0] pf_data, pf_data_n;
    logic              pf_full, pf_full_n;

    logic ser_out_n, busy_n, frame_done_n, underrun_n, len_err_n;
    logic req_ready_n, byte_ready_n;
    logic accept, byte_hs, load, starve;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (req_valid && (req_len != '0)) state_n = START;
            START:   state_n = HDR;
            HDR:     if (bit_cnt == BIT_W'(7)) state_n = DATA;
            DATA:    if ((bit_cnt == BIT_W'(7)) && (byte_cnt == len_q - LEN_W'(1))) state_n = STOP;
            STOP:    state_n = (MIN_GAP == 0) ? IDLE : GAP;
            GAP:     if (gap_cnt == GAP_LAST) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Datapath next values; ser_out is taken from the next shift-register LSB so it stays a flop
    always_comb begin
        port_n     = port_q;
        len_n      = len_q;
        bit_cnt_n  = bit_cnt;
        byte_cnt_n = byte_cnt;
        fetched_n  = fetched;
        gap_cnt_n  = gap_cnt;
        shreg_n    = shreg;
        pf_data_n  = pf_data;
        pf_full_n  = pf_full;
        underrun_n = underrun;

        accept    = (state == IDLE) && req_valid;
        byte_hs   = byte_valid && byte_ready;
        load      = (bit_cnt == BIT_W'(7)) && (state_n == DATA);
        starve    = load && !pf_full && !byte_hs;
        len_err_n = accept && (req_len == '0);

        if (accept && (req_len != '0)) begin
            port_n     = req_port;
            len_n      = req_len;
            bit_cnt_n  = '0;
            byte_cnt_n = '0;
            fetched_n  = '0;
        end

        if (state == START) begin
            shreg_n = {len_q, port_q};
        end

        if ((state == HDR) || (state == DATA)) begin
            bit_cnt_n = bit_cnt + BIT_W'(1);
            shreg_n   = {1'b0, shreg[BYTE_W-1:1]};
            // A starved slot still consumes a byte position so the frame length never changes
            if (byte_hs || starve) begin
                fetched_n = fetched + LEN_W'(1);
            end
            if (load) begin
                pf_full_n = 1'b0;
                if (pf_full) begin
                    shreg_n = pf_data;
                end else if (byte_hs) begin
                    shreg_n = byte_data;
                end else begin
                    shreg_n    = '0;
                    underrun_n = 1'b1;
                end
            end else if (byte_hs) begin
                pf_full_n = 1'b1;
                pf_data_n = byte_data;
            end
            if ((state == DATA) && (bit_cnt == BIT_W'(7))) begin
                byte_cnt_n = byte_cnt + LEN_W'(1);
            end
        end

        if (state == STOP) begin
            gap_cnt_n = '0;
        end
        if (state == GAP) begin
            gap_cnt_n = gap_cnt + GAP_W'(1);
        end

        case (state_n)
            START:     ser_out_n = 1'b0;
            HDR, DATA: ser_out_n = shreg_n[0];
            default:   ser_out_n = 1'b1;
        endcase

        busy_n       = (state_n != IDLE);
        req_ready_n  = (state_n == IDLE);
        frame_done_n = (state_n == STOP);
        byte_ready_n = !pf_full_n && ((state_n == HDR) || (state_n == DATA)) && (fetched_n < len_n);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            port_q     <= '0;
            len_q      <= '0;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            fetched    <= '0;
            gap_cnt    <= '0;
            shreg      <= '0;
            pf_data    <= '0;
            pf_full    <= 1'b0;
            ser_out    <= 1'b1;
            req_ready  <= 1'b1;
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
            len_err    <= 1'b0;
        end else begin
            port_q     <= port_n;
            len_q      <= len_n;
            bit_cnt    <= bit_cnt_n;
            byte_cnt   <= byte_cnt_n;
            fetched    <= fetched_n;
            gap_cnt    <= gap_cnt_n;
            shreg      <= shreg_n;
            pf_data    <= pf_data_n;
            pf_full    <= pf_full_n;
            ser_out    <= ser_out_n;
            req_ready  <= req_ready_n;
            byte_ready <= byte_ready_n;
            busy       <= busy_n;
            frame_done <= frame_done_n;
            underrun   <= underrun_n;
            len_err    <= len_err_n;
        end
    end

endmodule

// File: tb/tb_mssd_frame_serializer.sv
// Directed bench for mssd_frame_serializer: one instance with MIN_GAP=1 and one
// with MIN_GAP=0, selected by sel; a byte feeder process supplies payload.
module tb_mssd_frame_serializer;

    localparam int NONE = 1 << 30;
    // Hand-derived streams: start | port | len | payload LSB first | stop | gap
    localparam logic [0:18] T1_BITS = 19'b0_01_100000_10100101_1_1;
    localparam logic [0:18] T6_BITS = 19'b0_11_100000_01011010_1_1;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic [1:0] req_port;
    logic [5:0] req_len;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       sel;

    logic a_req_ready, a_byte_ready, a_ser, a_busy, a_fdone, a_ur, a_lerr;
    logic b_req_ready, b_byte_ready, b_ser, b_busy, b_fdone, b_ur, b_lerr;
    logic rreq, rdy, ser, busy, fdone, ur, lerr;

    int n_checks = 0;
    int n_err    = 0;

    logic [7:0] src_q[$];
    logic [7:0] exp_data[$];
    logic       exp_q[$];
    int src_gen    = 0;
    int src_period = 1;
    int src_limit  = NONE;
    int late_at    = NONE;
    int cyc        = 0;
    int hs_cnt     = 0;
    int hs0;
    int hs_snap;

    mssd_frame_serializer #(.MIN_GAP(1)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(req_valid && !sel), .req_ready(a_req_ready),
        .req_port(req_port), .req_len(req_len),
        .byte_valid(byte_valid && !sel), .byte_data(byte_data), .byte_ready(a_byte_ready),
        .ser_out(a_ser), .busy(a_busy), .frame_done(a_fdone),
        .underrun(a_ur), .len_err(a_lerr)
    );

    mssd_frame_serializer #(.MIN_GAP(0)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(req_valid && sel), .req_ready(b_req_ready),
        .req_port(req_port), .req_len(req_len),
        .byte_valid(byte_valid && sel), .byte_data(byte_data), .byte_ready(b_byte_ready),
        .ser_out(b_ser), .busy(b_busy), .frame_done(b_fdone),
        .underrun(b_ur), .len_err(b_lerr)
    );

    assign rreq  = sel ? b_req_ready  : a_req_ready;
    assign rdy   = sel ? b_byte_ready : a_byte_ready;
    assign ser   = sel ? b_ser        : a_ser;
    assign busy  = sel ? b_busy       : a_busy;
    assign fdone = sel ? b_fdone      : a_fdone;
    assign ur    = sel ? b_ur         : a_ur;
    assign lerr  = sel ? b_lerr       : a_lerr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Byte source: presents src_q in order, throttled and optionally withheld
    initial begin
        int idx;
        int seen_gen;
        idx = 0;
        seen_gen = 0;
        byte_valid = 1'b0;
        byte_data = 8'h00;
        forever begin
            @(posedge clk);
            cyc++;
            #2;
            if (seen_gen != src_gen) begin
                seen_gen = src_gen;
                idx = 0;
            end
            if (idx < src_q.size() && (cyc % src_period) == 0 && (idx < src_limit || cyc >= late_at)) begin
                byte_valid = 1'b1;
                byte_data = src_q[idx];
            end else begin
                byte_valid = 1'b0;
            end
            @(negedge clk);
            if (byte_valid && rdy) begin
                hs_cnt++;
                idx++;
            end
        end
    end

    task automatic build_exp(input logic [1:0] port, input logic [5:0] len, input int trail);
        exp_q.delete();
        exp_q.push_back(1'b0);
        for (int i = 0; i < 2; i++) exp_q.push_back(port[i]);
        for (int i = 0; i < 6; i++) exp_q.push_back(len[i]);
        foreach (exp_data[k]) begin
            for (int b = 0; b < 8; b++) exp_q.push_back(exp_data[k][b]);
        end
        exp_q.push_back(1'b1);
        for (int i = 0; i < trail; i++) exp_q.push_back(1'b1);
    endtask

    task automatic load_bits(input logic [0:18] v);
        exp_q.delete();
        for (int i = 0; i < 19; i++) exp_q.push_back(v[i]);
    endtask

    // Walks exp_q one cycle at a time starting at the cycle after the accept edge
    task automatic run_stream(input string tag, input int stop_idx, input int ur_from);
        int ser_bad;
        int fd_bad;
        int ur_bad;
        int first;
        ser_bad = 0;
        fd_bad = 0;
        ur_bad = 0;
        first = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (ser !== exp_q[i]) begin
                ser_bad++;
                if (first < 0) first = i;
            end
            if (fdone !== (i == stop_idx)) fd_bad++;
            if (ur !== (i >= ur_from)) ur_bad++;
            @(posedge clk);
            #1;
        end
        check($sformatf("%s_ser_bit_errors(first_bad=%0d)", tag, first), ser_bad, 0);
        check($sformatf("%s_frame_done_errors", tag), fd_bad, 0);
        check($sformatf("%s_underrun_errors", tag), ur_bad, 0);
    endtask

    task automatic request(input logic [1:0] port, input logic [5:0] len);
        req_port = port;
        req_len = len;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        req_port = 2'd0;
        req_len = 6'd0;
        sel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        check("reset_ser_out", ser, 1'b1);
        check("reset_req_ready", rreq, 1'b1);
        check("reset_byte_ready", rdy, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_frame_done", fdone, 1'b0);
        check("reset_underrun", ur, 1'b0);
        check("reset_len_err", lerr, 1'b0);

        // Single frame, port 2, len 1, byte 0xA5
        src_q = '{8'hA5};
        src_gen++;
        hs0 = hs_cnt;
        request(2'd2, 6'd1);
        check("t1_busy_start", busy, 1'b1);
        check("t1_req_ready_start", rreq, 1'b0);
        load_bits(T1_BITS);
        run_stream("t1", 17, NONE);
        check("t1_req_ready_after_gap", rreq, 1'b1);
        check("t1_busy_after_gap", busy, 1'b0);
        check("t1_handshakes", hs_cnt - hs0, 1);

        // Zero length descriptor is dropped
        src_q.delete();
        src_gen++;
        request(2'd1, 6'd0);
        check("t4_len_err_pulse", lerr, 1'b1);
        check("t4_ser_idle", ser, 1'b1);
        check("t4_busy", busy, 1'b0);
        check("t4_req_ready", rreq, 1'b1);
        @(posedge clk);
        #1;
        check("t4_len_err_cleared", lerr, 1'b0);
        check("t4_ser_idle_next", ser, 1'b1);
        check("t4_busy_next", busy, 1'b0);

        // Max length, byte_valid only every 5th cycle
        src_q.delete();
        exp_data.delete();
        for (int k = 0; k < 63; k++) begin
            src_q.push_back(8'(k * 37 + 5));
            exp_data.push_back(8'(k * 37 + 5));
        end
        src_period = 5;
        src_gen++;
        hs0 = hs_cnt;
        request(2'd1, 6'd63);
        build_exp(2'd1, 6'd63, 1);
        run_stream("t5", 513, NONE);
        check("t5_handshakes", hs_cnt - hs0, 63);
        check("t5_exp_len", exp_q.size(), 515);
        src_period = 1;

        // Underrun: second byte withheld past its slot
        src_q = '{8'h3C, 8'h99};
        exp_data = '{8'h3C, 8'h00};
        src_limit = 1;
        src_gen++;
        hs0 = hs_cnt;
        request(2'd0, 6'd2);
        late_at = cyc + 20;
        build_exp(2'd0, 6'd2, 1);
        run_stream("t3", 25, 17);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check("t3_handshakes", hs_cnt - hs0, 1);
        check("t3_underrun_sticky", ur, 1'b1);
        check("t3_busy_idle", busy, 1'b0);
        src_limit = NONE;
        late_at = NONE;

        // Back-to-back on the MIN_GAP=0 instance, request held valid
        sel = 1'b1;
        src_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        src_gen++;
        hs0 = hs_cnt;
        req_port = 2'd1;
        req_len = 6'd2;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_port = 2'd3;
        req_len = 6'd3;
        exp_data = '{8'h11, 8'h22};
        build_exp(2'd1, 6'd2, 1);
        run_stream("t2a", 25, NONE);
        req_valid = 1'b0;
        check("t2_second_accepted_busy", busy, 1'b1);
        exp_data = '{8'h33, 8'h44, 8'h55};
        build_exp(2'd3, 6'd3, 1);
        run_stream("t2b", 33, NONE);
        check("t2_handshakes", hs_cnt - hs0, 5);
        check("t2_idle_req_ready", rreq, 1'b1);
        sel = 1'b0;

        // Asynchronous reset mid-DATA, between clock edges
        src_q = '{8'hC3, 8'hC3, 8'hC3, 8'hC3};
        src_gen++;
        request(2'd0, 6'd4);
        repeat (13) begin
            @(posedge clk);
            #1;
        end
        check("t6_busy_before_reset", busy, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_ser_during_reset", ser, 1'b1);
        check("t6_busy_during_reset", busy, 1'b0);
        check("t6_byte_ready_during_reset", rdy, 1'b0);
        check("t6_underrun_cleared", ur, 1'b0);
        check("t6_frame_done_during_reset", fdone, 1'b0);
        hs_snap = hs_cnt;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("t6_no_accept_in_reset", hs_cnt - hs_snap, 0);
        @(posedge clk);
        #1;
        check("t6_req_ready_after_release", rreq, 1'b1);
        src_q = '{8'h5A};
        src_gen++;
        hs0 = hs_cnt;
        request(2'd3, 6'd1);
        load_bits(T6_BITS);
        run_stream("t6", 17, NONE);
        check("t6_handshakes", hs_cnt - hs0, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
